lut_config_loader: RTL and testbench

Receives a streamed configuration bitstream over a valid/ready word interface and writes it into the LUT configuration memories of the FPGA fabric (`fgpa`), one 32-bit word per cycle. It replaces direct memory preloading with an in-fabric load path. It validates the frame header, tracks LUT and word position, and raises `cfg_done` so the fabric can be released only after a complete, clean load.

---
 rtl/lut_config_loader.sv | 88 ++++++++
 tb/tb_lut_config_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// lut_config_loader: streamed LUT config loader with header validation; define LUT_CFG_CHECKSUM_EN to add the XOR checksum word
module lut_config_loader #(
    parameter int          N_LUTS = 6,
    parameter logic [15:0] MAGIC  = 16'hC0F6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [31:0]       cfg_data,
    output logic              cfg_ready,
    input  logic              cfg_clear,
    output logic [N_LUTS-1:0] lut_we,
    output logic              lut_waddr,
    output logic [31:0]       lut_wdata,
    output logic              cfg_done,
    output logic              cfg_error
);
    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef LUT_CFG_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } state_t;
    state_t state, state_n;
    logic [7:0] ptr, last_ptr;
    logic tog, xfer, hdr, hdr_ok, wr, last;
`ifdef LUT_CFG_CHECKSUM_EN
    logic [31:0] acc;
`endif
    assign cfg_ready = state != ERROR;
    assign cfg_done  = state == DONE;
    assign cfg_error = state == ERROR;
    assign xfer      = cfg_valid && cfg_ready;
    assign hdr       = xfer && (state == IDLE || state == DONE);
    assign hdr_ok    = cfg_data[31:16] == MAGIC && cfg_data[7:0] != 8'd0 &&
                       9'(cfg_data[15:8]) + 9'(cfg_data[7:0]) <= 9'(N_LUTS);
    assign wr        = state == DATA && xfer;
    assign last      = wr && tog && ptr == last_ptr;
    always_comb begin
        state_n = state;
`ifdef LUT_CFG_CHECKSUM_EN
        state_n = hdr ? (hdr_ok ? DATA : ERROR) :
                  last ? CHECK :
                  (state == CHECK && xfer) ? (cfg_data == acc ? DONE : ERROR) :
                  (state == ERROR && cfg_clear) ? IDLE : state;
`else
        state_n = hdr ? (hdr_ok ? DATA : ERROR) :
                  last ? DONE :
                  (state == ERROR && cfg_clear) ? IDLE : state;
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            last_ptr  <= '0;
            tog       <= 1'b0;
            lut_we    <= '0;
            lut_waddr <= 1'b0;
            lut_wdata <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            state  <= state_n;
            lut_we <= wr ? N_LUTS'(1) << ptr : '0;
            if (hdr) begin
                ptr      <= cfg_data[15:8];
                last_ptr <= cfg_data[15:8] + cfg_data[7:0] - 8'd1;
                tog      <= 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
                acc      <= '0;
`endif
            end else if (wr) begin
                ptr       <= ptr + {7'd0, tog};
                tog       <= ~tog;
                lut_waddr <= tog;
                lut_wdata <= cfg_data;
`ifdef LUT_CFG_CHECKSUM_EN
                acc       <= acc ^ cfg_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed checks of header validation, LUT write strobes, done/error flags
module tb_lut_config_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cfg_valid = 1'b0;
    logic [31:0] cfg_data = '0;
    logic cfg_clear = 1'b0;
    logic cfg_ready, lut_waddr, cfg_done, cfg_error;
    logic [5:0] lut_we;
    logic [31:0] lut_wdata;
    int total = 0;
    int passed = 0;
    lut_config_loader #(.N_LUTS(6), .MAGIC(16'hC0F6)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_clear(cfg_clear), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .cfg_done(cfg_done),
        .cfg_error(cfg_error)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask
    task automatic send(input logic [31:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
    endtask
    task automatic idle();
        @(posedge clock);
        #1;
    endtask
    task automatic clear();
        cfg_clear = 1'b1;
        idle();
        cfg_clear = 1'b0;
    endtask
    task automatic wr(input string tag, input logic [5:0] we, input logic a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(lut_we), 32'(we));
        chk({tag, "_addr"}, 32'(lut_waddr), 32'(a));
        chk({tag, "_data"}, lut_wdata, d);
    endtask
    task automatic finish_frame(input logic [31:0] sum);
`ifdef LUT_CFG_CHECKSUM_EN
        chk("pre_sum_done", 32'(cfg_done), 32'd0);
        send(sum);
        chk("sum_we", 32'(lut_we), 32'd0);
`endif
        chk("frame_done", 32'(cfg_done), 32'd1);
        chk("frame_err", 32'(cfg_error), 32'd0);
    endtask
    initial begin
        #2;
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_we", 32'(lut_we), 32'd0);
        chk("rst_addr", 32'(lut_waddr), 32'd0);
        chk("rst_data", lut_wdata, 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_err", 32'(cfg_error), 32'd0);
        idle();
        reset = 1'b0;
        idle();
        // Basic frame: LUT0 and LUT1, words back to back
        send(32'hC0F6_0002);
        chk("hdr_we", 32'(lut_we), 32'd0);
        send(32'h0000_6996); wr("w0", 6'b000001, 1'b0, 32'h0000_6996);
        send(32'h0000_0001); wr("w1", 6'b000001, 1'b1, 32'h0000_0001);
        send(32'h0000_E8E8); wr("w2", 6'b000010, 1'b0, 32'h0000_E8E8);
        send(32'h0000_0002); wr("w3", 6'b000010, 1'b1, 32'h0000_0002);
        finish_frame(32'h0000_817D);
        idle();
        chk("after_we", 32'(lut_we), 32'd0);
`ifdef LUT_CFG_CHECKSUM_EN
        send(32'hC0F6_0002);
        send(32'h0000_6996);
        send(32'h0000_0001);
        send(32'h0000_E8E8);
        send(32'h0000_0002);
        send(32'h0000_0000);
        chk("badsum_err", 32'(cfg_error), 32'd1);
        chk("badsum_ready", 32'(cfg_ready), 32'd0);
        chk("badsum_done", 32'(cfg_done), 32'd0);
        clear();
        chk("badsum_clr_ready", 32'(cfg_ready), 32'd1);
        chk("badsum_clr_err", 32'(cfg_error), 32'd0);
`endif
        send(32'hBEEF_0001);
        chk("magic_err", 32'(cfg_error), 32'd1);
        chk("magic_done", 32'(cfg_done), 32'd0);
        chk("magic_we", 32'(lut_we), 32'd0);
        send(32'h0000_1234);
        chk("magic_blocked_we", 32'(lut_we), 32'd0);
        chk("magic_ready", 32'(cfg_ready), 32'd0);
        clear();
        chk("magic_clr_ready", 32'(cfg_ready), 32'd1);
        chk("magic_clr_err", 32'(cfg_error), 32'd0);
        send(32'hC0F6_0502);
        chk("range_err", 32'(cfg_error), 32'd1);
        clear();
        send(32'hC0F6_0300);
        chk("zero_err", 32'(cfg_error), 32'd1);
        clear();
        send(32'hC0F6_0501);
        chk("edge_ok", 32'(cfg_error), 32'd0);
        idle(); chk("gap0_we", 32'(lut_we), 32'd0);
        send(32'hAAAA_5555); wr("g0", 6'b100000, 1'b0, 32'hAAAA_5555);
        idle(); chk("gap1_we", 32'(lut_we), 32'd0);
        send(32'h1234_5678); wr("g1", 6'b100000, 1'b1, 32'h1234_5678);
        idle(); chk("gap2_we", 32'(lut_we), 32'd0);
        finish_frame(32'hAAAA_5555 ^ 32'h1234_5678);
        send(32'hC0F6_0002);
        send(32'h0000_0011);
        send(32'h0000_0022);
        wr("pre_rst", 6'b000001, 1'b1, 32'h0000_0022);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(lut_we), 32'd0);
        chk("mid_rst_addr", 32'(lut_waddr), 32'd0);
        chk("mid_rst_data", lut_wdata, 32'd0);
        chk("mid_rst_done", 32'(cfg_done), 32'd0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        idle();
        reset = 1'b0;
        idle();
        send(32'hC0F6_0001);
        send(32'hCAFE_0000); wr("r0", 6'b000001, 1'b0, 32'hCAFE_0000);
        send(32'h0000_0001); wr("r1", 6'b000001, 1'b1, 32'h0000_0001);
        finish_frame(32'hCAFE_0001);
        send(32'hC0F6_0401);
        chk("rehdr_done", 32'(cfg_done), 32'd0);
        send(32'h0000_00F0); wr("h0", 6'b010000, 1'b0, 32'h0000_00F0);
        chk("rehdr_mid_done", 32'(cfg_done), 32'd0);
        send(32'h0000_000F); wr("h1", 6'b010000, 1'b1, 32'h0000_000F);
        finish_frame(32'h0000_00FF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
